// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM state encoding,
// grant encoding and a counter-width helper.
package memory_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARBITER_STATE_IDLE  = 2'd0,
    ARBITER_STATE_ISSUE = 2'd1,
    ARBITER_STATE_WAIT  = 2'd2,
    ARBITER_STATE_DONE  = 2'd3
  } arbiter_state_e;

  typedef enum logic {
    ARBITER_GRANT_INSTRUCTION = 1'b0,
    ARBITER_GRANT_DATA        = 1'b1
  } arbiter_grant_e;

  // Bits needed to hold values 0..max_value, never less than one bit.
  function automatic int counter_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/memory_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch
// and load/store, sequencing IDLE -> ISSUE -> WAIT -> DONE per access.
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEMORY_LATENCY = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     instructionRequest,
  input  logic [ADDRESS_WIDTH-1:0] instructionAddress,
  output logic [DATA_WIDTH-1:0]    instructionData,
  output logic                     instructionReady,
  input  logic                     dataRequest,
  input  logic                     dataWrite,
  input  logic [ADDRESS_WIDTH-1:0] dataAddress,
  input  logic [DATA_WIDTH-1:0]    dataWriteData,
  output logic [DATA_WIDTH-1:0]    dataReadData,
  output logic                     dataReady,
  output logic                     shouldStallFetch,
  output logic                     shouldStallMemory,
  output logic                     memoryEnable,
  output logic                     memoryWrite,
  output logic [ADDRESS_WIDTH-1:0] memoryAddress,
  output logic [DATA_WIDTH-1:0]    memoryWriteData,
  input  logic [DATA_WIDTH-1:0]    memoryReadData,
  output logic [1:0]               debugState
);

  localparam int CW = counter_width(MEMORY_LATENCY);
  localparam int SW = counter_width(STARVE_LIMIT);

  // Handshake: a requester raises *Request with stable address/data and holds
  // it until its *Ready pulses for exactly one cycle (the DONE state); the
  // arbiter then returns to IDLE so the requester can drop or renew it.

  arbiter_state_e           state_q, state_d;
  arbiter_grant_e           grant_q, grant_d;
  logic                     write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [CW-1:0]            count_q, count_d;
  logic [SW-1:0]            starve_q, starve_d;
  logic [DATA_WIDTH-1:0]    idata_q, idata_d;
  logic [DATA_WIDTH-1:0]    ddata_q, ddata_d;

  logic starved;
  assign starved = instructionRequest && (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    count_d  = count_q;
    starve_d = starve_q;
    idata_d  = idata_q;
    ddata_d  = ddata_q;
    case (state_q)
      ARBITER_STATE_IDLE: begin
        if (dataRequest && !starved) begin
          state_d = ARBITER_STATE_ISSUE;
          grant_d = ARBITER_GRANT_DATA;
          write_d = dataWrite;
          addr_d  = dataAddress;
          wdata_d = dataWriteData;
          if (!instructionRequest) begin
            starve_d = '0;
          end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (instructionRequest) begin
          state_d  = ARBITER_STATE_ISSUE;
          grant_d  = ARBITER_GRANT_INSTRUCTION;
          write_d  = 1'b0;
          addr_d   = instructionAddress;
          starve_d = '0;
        end
      end
      ARBITER_STATE_ISSUE: begin
        state_d = ARBITER_STATE_WAIT;
        count_d = CW'(MEMORY_LATENCY);
      end
      ARBITER_STATE_WAIT: begin
        // Count of 1 marks the cycle memoryReadData is valid for this access.
        if (count_q == CW'(1)) begin
          state_d = ARBITER_STATE_DONE;
          if (grant_q == ARBITER_GRANT_INSTRUCTION) begin
            idata_d = memoryReadData;
          end else if (!write_q) begin
            ddata_d = memoryReadData;
          end
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      ARBITER_STATE_DONE: begin
        state_d = ARBITER_STATE_IDLE;
      end
      default: state_d = ARBITER_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARBITER_STATE_IDLE;
      grant_q  <= ARBITER_GRANT_INSTRUCTION;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      count_q  <= '0;
      starve_q <= '0;
      idata_q  <= '0;
      ddata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      idata_q  <= idata_d;
      ddata_q  <= ddata_d;
    end
  end

  assign memoryEnable      = (state_q == ARBITER_STATE_ISSUE);
  assign memoryWrite       = memoryEnable && (grant_q == ARBITER_GRANT_DATA) && write_q;
  assign memoryAddress     = addr_q;
  assign memoryWriteData   = wdata_q;
  assign instructionReady  = (state_q == ARBITER_STATE_DONE) && (grant_q == ARBITER_GRANT_INSTRUCTION);
  assign dataReady         = (state_q == ARBITER_STATE_DONE) && (grant_q == ARBITER_GRANT_DATA);
  assign instructionData   = idata_q;
  assign dataReadData      = ddata_q;
  assign shouldStallFetch  = instructionRequest && !instructionReady;
  assign shouldStallMemory = dataRequest && !dataReady;
  assign debugState        = state_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: cycle table for fetch/load/store, then
// hand-written starvation, mid-access reset and latency-1 sequences.
module tb_memory_port_arbiter;

  localparam logic [31:0] JUNK = 32'hBADBAD00;
  localparam logic [31:0] ID1  = 32'h8C010004;
  localparam logic [31:0] I2   = 32'h33334444;
  localparam logic [31:0] D2   = 32'h11112222;
  localparam logic [31:0] W3   = 32'hDEADBEEF;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // Latency-2 instance signals
  logic        ireq, irdy, dreq, dwr, drdy, stf, stm, men, mwr;
  logic [31:0] iaddr, idata, daddr, dwdata, ddata, maddr, mwdata, mrdata;
  logic [1:0]  dbg;
  // Latency-1 instance signals
  logic        ireq1, irdy1, drdy1, stf1, stm1, men1, mwr1;
  logic [31:0] iaddr1, idata1, ddata1, maddr1, mwdata1, mrdata1;
  logic [1:0]  dbg1;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;

  memory_port_arbiter #(.MEMORY_LATENCY(2), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .instructionRequest(ireq), .instructionAddress(iaddr),
    .instructionData(idata), .instructionReady(irdy),
    .dataRequest(dreq), .dataWrite(dwr), .dataAddress(daddr),
    .dataWriteData(dwdata), .dataReadData(ddata), .dataReady(drdy),
    .shouldStallFetch(stf), .shouldStallMemory(stm),
    .memoryEnable(men), .memoryWrite(mwr), .memoryAddress(maddr),
    .memoryWriteData(mwdata), .memoryReadData(mrdata), .debugState(dbg)
  );

  memory_port_arbiter #(.MEMORY_LATENCY(1), .STARVE_LIMIT(4)) dut_l1 (
    .clock(clock), .reset_n(reset_n),
    .instructionRequest(ireq1), .instructionAddress(iaddr1),
    .instructionData(idata1), .instructionReady(irdy1),
    .dataRequest(zero1), .dataWrite(zero1), .dataAddress(zero32),
    .dataWriteData(zero32), .dataReadData(ddata1), .dataReady(drdy1),
    .shouldStallFetch(stf1), .shouldStallMemory(stm1),
    .memoryEnable(men1), .memoryWrite(mwr1), .memoryAddress(maddr1),
    .memoryWriteData(mwdata1), .memoryReadData(mrdata1), .debugState(dbg1)
  );

  // Memory model: data for an access issued in cycle c appears during c+L.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] p0 = JUNK, p1 = JUNK, p2 = JUNK, q0 = JUNK, q1 = JUNK;
  assign mrdata  = p2;
  assign mrdata1 = q1;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(posedge clock) begin
    #1;
    p2 = p1;
    p1 = p0;
    p0 = JUNK;
    if (men) begin
      if (mwr) mem[maddr] = mwdata;
      else     p0 = mem_rd(maddr);
    end
    q1 = q0;
    q0 = men1 ? mem_rd(maddr1) : JUNK;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [1:0]  st;
    logic        en;
    logic        wr;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        irdy;
    logic        drdy;
    logic [31:0] idata;
    logic [31:0] ddata;
    logic        sf;
    logic        sm;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] dd, input logic [1:0] st,
                     input logic en, input logic wr, input logic [31:0] ma, input logic [31:0] mw,
                     input logic ird, input logic drd, input logic [31:0] id, input logic [31:0] ddv,
                     input logic sf, input logic sm);
    vec_t v;
    v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwr = dw; v.daddr = da; v.dwdata = dd;
    v.st = st; v.en = en; v.wr = wr; v.maddr = ma; v.mwdata = mw;
    v.irdy = ird; v.drdy = drd; v.idata = id; v.ddata = ddv; v.sf = sf; v.sm = sm;
    vecs.push_back(v);
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  initial begin
    int nd, ni, cyc, rdy_cyc, pulses;
    logic [31:0] rec;
    bit done;

    reset_n = 1'b0;
    ireq = 0; iaddr = 0; dreq = 0; dwr = 0; daddr = 0; dwdata = 0;
    ireq1 = 0; iaddr1 = 0;
    mem[32'h40]  = ID1;
    mem[32'h44]  = I2;
    mem[32'h48]  = 32'h55556666;
    mem[32'h100] = D2;
    mem[32'h300] = 32'h77778888;
    repeat (2) @(negedge clock);
    chk("reset.state", 32'(dbg), 32'd0);
    chk("reset.enable", 32'(men), 32'd0);
    reset_n = 1'b1;
    next_cycle();

    // Fetch only
    for (int c = 0; c < 6; c++) begin
      logic [1:0] s;
      s = (c == 0 || c == 5) ? 2'd0 : (c == 1) ? 2'd1 : (c == 4) ? 2'd3 : 2'd2;
      add(c < 5, 32'h40, 0, 0, 0, 0, s, c == 1, 0, (c == 0) ? 32'h0 : 32'h40, 0,
          c == 4, 0, (c >= 4) ? ID1 : 32'h0, 0, c < 4, 0);
    end
    // Simultaneous: data first, instruction issues at cycle 6
    for (int c = 0; c < 11; c++) begin
      logic [1:0] s;
      s = (c == 0 || c == 5 || c == 10) ? 2'd0 : (c == 1 || c == 6) ? 2'd1 :
          (c == 4 || c == 9) ? 2'd3 : 2'd2;
      add(c < 10, 32'h44, c < 5, 0, 32'h100, 0, s, c == 1 || c == 6, 0,
          (c == 0) ? 32'h40 : (c < 6) ? 32'h100 : 32'h44, 0,
          c == 9, c == 4, (c >= 9) ? I2 : ID1, (c >= 4) ? D2 : 32'h0, c < 9, c < 4);
    end
    // Store, then load the same address back
    for (int c = 0; c < 6; c++) begin
      logic [1:0] s;
      s = (c == 0 || c == 5) ? 2'd0 : (c == 1) ? 2'd1 : (c == 4) ? 2'd3 : 2'd2;
      add(0, 0, c < 5, 1, 32'h200, W3, s, c == 1, c == 1, (c == 0) ? 32'h44 : 32'h200,
          (c == 0) ? 32'h0 : W3, 0, c == 4, I2, D2, 0, c < 4);
    end
    for (int c = 0; c < 6; c++) begin
      logic [1:0] s;
      s = (c == 0 || c == 5) ? 2'd0 : (c == 1) ? 2'd1 : (c == 4) ? 2'd3 : 2'd2;
      add(0, 0, c < 5, 0, 32'h200, 0, s, c == 1, 0, 32'h200, (c == 0) ? W3 : 32'h0,
          0, c == 4, I2, (c >= 4) ? W3 : D2, 0, c < 4);
    end

    foreach (vecs[i]) begin
      ireq = vecs[i].ireq; iaddr = vecs[i].iaddr; dreq = vecs[i].dreq;
      dwr = vecs[i].dwr; daddr = vecs[i].daddr; dwdata = vecs[i].dwdata;
      @(negedge clock);
      chk($sformatf("row%0d.state", i), 32'(dbg), 32'(vecs[i].st));
      chk($sformatf("row%0d.memEnable", i), 32'(men), 32'(vecs[i].en));
      chk($sformatf("row%0d.memWrite", i), 32'(mwr), 32'(vecs[i].wr));
      chk($sformatf("row%0d.memAddress", i), maddr, vecs[i].maddr);
      chk($sformatf("row%0d.memWriteData", i), mwdata, vecs[i].mwdata);
      chk($sformatf("row%0d.instrReady", i), 32'(irdy), 32'(vecs[i].irdy));
      chk($sformatf("row%0d.dataReady", i), 32'(drdy), 32'(vecs[i].drdy));
      chk($sformatf("row%0d.instrData", i), idata, vecs[i].idata);
      chk($sformatf("row%0d.dataReadData", i), ddata, vecs[i].ddata);
      chk($sformatf("row%0d.stallFetch", i), 32'(stf), 32'(vecs[i].sf));
      chk($sformatf("row%0d.stallMemory", i), 32'(stm), 32'(vecs[i].sm));
      next_cycle();
    end

    // Starvation: 6 back-to-back loads with a fetch pending throughout
    ireq = 1; iaddr = 32'h48; dreq = 1; dwr = 0; daddr = 32'h300; dwdata = 0;
    nd = 0; ni = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      if (men) got_q.push_back(maddr);
      if (drdy) nd++;
      if (irdy) ni++;
      next_cycle();
      dreq = (nd < 6);
      if (nd >= 6 && ni >= 2) begin
        ireq = 0;
        done = 1;
      end
    end
    chk("starve.completed", 32'(done), 32'd1);
    exp_q = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h48, 32'h300, 32'h300, 32'h48};
    chk("starve.grant_count", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got_q.size()) chk($sformatf("starve.grant%0d", i), got_q[i], exp_q[i]);
      else chk($sformatf("starve.grant%0d", i), JUNK, exp_q[i]);
    end

    // Reset in the WAIT phase of a load
    dreq = 1; daddr = 32'h100;
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clock);
      if (dbg == 2'd2) done = 1;
    end
    chk("rst.reached_wait", 32'(done), 32'd1);
    #2;
    reset_n = 1'b0;
    dreq = 0;
    #1;
    chk("rst.state", 32'(dbg), 32'd0);
    chk("rst.memEnable", 32'(men), 32'd0);
    chk("rst.memWrite", 32'(mwr), 32'd0);
    chk("rst.memAddress", maddr, 32'h0);
    chk("rst.memWriteData", mwdata, 32'h0);
    chk("rst.instrData", idata, 32'h0);
    chk("rst.dataReadData", ddata, 32'h0);
    chk("rst.instrReady", 32'(irdy), 32'd0);
    chk("rst.dataReady", 32'(drdy), 32'd0);
    chk("rst.stallMemory", 32'(stm), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (drdy || dbg != 2'd0) pulses++;
    end
    chk("rst.no_activity_after", 32'(pulses), 32'd0);
    next_cycle();
    ireq = 1; iaddr = 32'h40;
    rdy_cyc = -1;
    for (int c = 0; c < 20 && rdy_cyc < 0; c++) begin
      @(negedge clock);
      if (irdy) rdy_cyc = c;
      else next_cycle();
    end
    chk("rst.refetch_cycle", 32'(rdy_cyc), 32'd4);
    chk("rst.refetch_data", idata, ID1);
    next_cycle();
    ireq = 0;

    // Latency-1 build: single fetch
    next_cycle();
    ireq1 = 1; iaddr1 = 32'h40;
    rdy_cyc = -1; rec = 32'h0; cyc = 0;
    for (int c = 0; c < 20 && rdy_cyc < 0; c++) begin
      @(negedge clock);
      if (c == 2) rec = mrdata1;
      if (irdy1) rdy_cyc = c;
      next_cycle();
      cyc = c;
    end
    ireq1 = 0;
    chk("l1.ready_cycle", 32'(rdy_cyc), 32'd3);
    chk("l1.data_vs_cycle2", idata1, rec);
    chk("l1.data_value", idata1, ID1);
    chk("l1.last_cycle", 32'(cyc), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
